// File: rtl/regfile_arbiter.sv
// Write-port owner for the 16x16 register file: arbitrates CPU and debug access on clk2 ticks
// and scrubs every register to INIT_VAL after reset or on clear_req.
module regfile_arbiter #(
  parameter int DW = 16,
  parameter int AW = 4,
  parameter logic [DW-1:0] INIT_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk2,
  input  logic          clear_req,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q,
  output logic          scrub_busy
);

  typedef enum logic [1:0] {
    ST_SCRUB   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_GRANT_C = 2'd2,
    ST_GRANT_D = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] addr_r, addr_s;
  logic [DW-1:0] wdata_r, wdata_s;
  logic          we_r, we_s;
  logic          c_done_s, d_done_s;
  logic          ram_we_s;
  logic          c_ack_r, d_ack_r;
  logic [DW-1:0] c_rdata_r, d_rdata_r;

  // addr_r doubles as the scrub pointer and the latched grant address, so ram_a holds when idle
  assign ram_a      = addr_r;
  assign ram_d      = (state_r == ST_SCRUB) ? INIT_VAL : wdata_r;
  assign ram_we     = ram_we_s & ~rst;
  assign scrub_busy = (state_r == ST_SCRUB);
  assign c_ack      = c_ack_r;
  assign d_ack      = d_ack_r;
  assign c_rdata    = c_rdata_r;
  assign d_rdata    = d_rdata_r;

  // Next-state, address/data latching and arbitration evaluated for the coming tick
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    we_s     = we_r;
    c_done_s = (state_r == ST_GRANT_C);
    d_done_s = (state_r == ST_GRANT_D);
    case (state_r)
      ST_SCRUB: begin
        if (addr_r == {AW{1'b1}}) begin
          state_s = ST_IDLE;
          addr_s  = {AW{1'b0}};
        end else begin
          state_s = ST_SCRUB;
          addr_s  = addr_r + AW'(1);
        end
      end
      default: begin
        // A requester whose grant closes at this tick sits out one slot
        if (clear_req) begin
          state_s = ST_SCRUB;
          addr_s  = {AW{1'b0}};
          we_s    = 1'b0;
        end else if (c_req && !c_done_s) begin
          state_s = ST_GRANT_C;
          addr_s  = c_addr;
          wdata_s = c_wdata;
          we_s    = c_we;
        end else if (d_req && !d_done_s) begin
          state_s = ST_GRANT_D;
          addr_s  = d_addr;
          we_s    = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
    endcase
  end

  // RAM write strobe: one write per tick while scrubbing or in a CPU write grant
  always_comb begin
    ram_we_s = 1'b0;
    case (state_r)
      ST_SCRUB:   ram_we_s = clk2;
      ST_GRANT_C: ram_we_s = we_r & clk2;
      default:    ram_we_s = 1'b0;
    endcase
  end

  // State, latches and registered acks/read data; everything advances only on ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_SCRUB;
      addr_r    <= {AW{1'b0}};
      wdata_r   <= {DW{1'b0}};
      we_r      <= 1'b0;
      c_ack_r   <= 1'b0;
      d_ack_r   <= 1'b0;
      c_rdata_r <= {DW{1'b0}};
      d_rdata_r <= {DW{1'b0}};
    end else if (clk2) begin
      state_r <= state_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      we_r    <= we_s;
      c_ack_r <= c_done_s;
      d_ack_r <= d_done_s;
      // ram_q is the async read of the old contents: read-before-write
      if (c_done_s) c_rdata_r <= ram_q;
      if (d_done_s) d_rdata_r <= ram_q;
    end
  end

endmodule
